stencil_cache_ctrl: RTL and testbench
=====================================

# stencil_cache_ctrl

Parametrised stencil (mask-bit) cache for the GPU rasteriser. It generalises the two-bank, per-pixel-bit stencil store with configurable geometry and a valid/ready handshake on both ports. It arbitrates read/write bank conflicts and adds a bulk fill engine, so a region can be cleared or set without host-side write loops. It sits between the rasteriser's stencil test/update path and VRAM-side stencil sync logic.

## Interface
Parameters:
- ADR_W, 15: word address width; one word holds PIX pixel bits.
- PIX, 16: pixels per word; even, power of 2; PW = log2(PIX/2) is the pair index width.
- BANK_BIT, 6: address bit that selects the bank (1 = A, 0 = B); the remaining ADR_W-1 bits form the row.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_fullMode  in  1  1 = whole-word access; 0 = pair access.
- i_wrValid  in  1  write request.
- o_wrReady  out  1  write accepted when i_wrValid & o_wrReady.
- i_wrAdr  in  ADR_W  write word address.
- i_wrPair  in  PW  pair index (pair mode).
- i_wrSelect  in  2  pixel-in-pair write enables (pair mode).
- i_wrValue  in  2  pair value; bit0 → pixel 2p, bit1 → pixel 2p+1.
- i_wrValue16  in  PIX  full-mode data.
- i_wrMask16  in  PIX  full-mode per-bit write enable.
- i_rdValid  in  1  read request.
- o_rdReady  out  1  read accepted when i_rdValid & o_rdReady.
- i_rdAdr  in  ADR_W  read word address.
- i_rdPair  in  PW  pair index for o_rdValue.
- o_rdValid  out  1  one-cycle pulse; read data valid.
- o_rdValue  out  2  selected pair, registered.
- o_rdValue16  out  PIX  whole word, registered.
- i_fillStart  in  1  start bulk fill (sampled only in IDLE).
- i_fillAdr  in  ADR_W  first word of the fill.
- i_fillCount  in  ADR_W+1  number of words to fill.
- i_fillValue  in  1  bit replicated into every pixel.
- o_fillBusy  out  1  high in FILL and DONE.
- o_fillDone  out  1  one-cycle pulse in DONE.

## Operation
- **Storage.** Two banks, each 2^(ADR_W-1) words of PIX bits, with per-bit write enable. The row is the address with BANK_BIT removed. Memory contents are not reset.
- **Write enables.**
  - Pair mode: bits 2p and 2p+1 are enabled by i_wrSelect[0] and i_wrSelect[1]; data is {PIX/2{i_wrValue}}.
  - Full mode: enables come from i_wrMask16; data is i_wrValue16.
- **o_wrReady** = !o_fillBusy.
- **Conflict.** A conflict exists when i_wrValid and the write bank equals the read bank, and either i_fullMode is set or i_wrPair == i_rdPair.
- **o_rdReady** = !o_fillBusy & !(conflict & !bypass_ok). bypass_ok is defined under Configuration. When a conflict blocks a read, the write wins and the read is retried by the requester.
- **Reads.** An accepted read registers the row/bank read. On the next cycle:
  - o_rdValid = 1;
  - o_rdValue16 = the word;
  - o_rdValue = o_rdValue16[2*rdPair+1 : 2*rdPair], using the pair index registered at accept.
  - Outputs hold until the next accepted read.
- **Fill FSM:** IDLE → FILL → DONE → IDLE.
  - IDLE: on i_fillStart, capture cursor = i_fillAdr and cnt = i_fillCount. Go to FILL if cnt != 0, else go straight to DONE. A write accepted in the same cycle as the start completes normally.
  - FILL: each cycle, write the whole word at cursor with all bits = i_fillValue (sampled at start); then cursor+1 (wraps mod 2^ADR_W) and cnt−1. When cnt reaches 1, go to DONE.
  - DONE: o_fillDone = 1 for one cycle, then return to IDLE.
  - i_fillStart outside IDLE is ignored.
- **Reset.** Asserting rst at any time forces:
  - FSM to IDLE;
  - o_rdValid, o_rdValue, o_rdValue16, o_fillBusy, o_fillDone to 0;
  - any in-flight fill is abandoned.

## Timing
- Read latency is 1 cycle from acceptance to o_rdValid.
- o_rdReady and o_wrReady are combinational from the current inputs and state.
- A fill of N words (N ≥ 1) keeps o_fillBusy high for N+1 cycles, starting the cycle after i_fillStart. o_fillDone is asserted in the last of those cycles. For N = 0, busy is high for 1 cycle.
- A write at edge k is visible to a read accepted at edge k+1 or later.

## Configuration
- **STENCIL_BYPASS_EN defined:** bypass_ok = 1 when the conflicting write has an identical full address. The read is accepted and returns write-first data: each written bit is replaced by the write data, other bits come from the array.
- **STENCIL_BYPASS_EN undefined:** bypass_ok = 0. Every conflict deasserts o_rdReady for that cycle.

## Test plan
- **Pair write/read.** Pair write adr 0x0045, pair 3, select 2'b11, value 2'b10; then read the same address, pair 3 → o_rdValid one cycle later, o_rdValue = 2'b10, o_rdValue16[7:6] = 2'b10.
- **Masked full-mode write.** Fill 0x00C0 with count 1, value 0. Then full-mode write 0x00C0, data 0xA5A5, mask 0x00FF; read it back → o_rdValue16 = 0x00A5.
- **Bank conflicts.**
  - Full-mode write 0x0040 plus read 0x0001 (different banks) → both accepted, o_rdReady = 1.
  - Full-mode write 0x0040 plus read 0x0041 (same bank) → o_rdReady = 0; the retry next cycle is accepted.
- **Same-address conflict.** Write and read 0x0100, pair 2, value 2'b01, both in the same cycle.
  - With the macro: o_rdReady = 1 and o_rdValue = 2'b01.
  - Without the macro: o_rdReady = 0; the retry next cycle returns 2'b01.
- **Wrapping fill.** Fill adr 0x7FFE, count 4, value 1 → o_fillBusy high 5 cycles and o_fillDone on the 5th; both ready outputs are 0 throughout. Words 0x7FFE, 0x7FFF, 0x0000 and 0x0001 then read 0xFFFF.
- **Reset mid-fill.** Start a fill with count 8, assert rst after 2 FILL cycles → o_fillBusy = 0 immediately and o_fillDone never pulses. After reset release, a new fill start is accepted.

Source files
------------

// File: rtl/stencil_cache_ctrl_if.sv
// stencil_cache_ctrl_if: host-facing bus of the stencil cache.
// Carries the write port, the read port and the bulk fill controls.
// The slave modport is the cache's view; the master modport is the requester's view.
interface stencil_cache_ctrl_if #(
    parameter int ADR_W = 15,
    parameter int PIX   = 16
);
    localparam int PW = (PIX > 2) ? $clog2(PIX / 2) : 1;

    // Write port
    logic              i_fullMode;
    logic              i_wrValid;
    logic              o_wrReady;
    logic [ADR_W-1:0]  i_wrAdr;
    logic [PW-1:0]     i_wrPair;
    logic [1:0]        i_wrSelect;
    logic [1:0]        i_wrValue;
    logic [PIX-1:0]    i_wrValue16;
    logic [PIX-1:0]    i_wrMask16;

    // Read port
    logic              i_rdValid;
    logic              o_rdReady;
    logic [ADR_W-1:0]  i_rdAdr;
    logic [PW-1:0]     i_rdPair;
    logic              o_rdValid;
    logic [1:0]        o_rdValue;
    logic [PIX-1:0]    o_rdValue16;

    // Bulk fill
    logic              i_fillStart;
    logic [ADR_W-1:0]  i_fillAdr;
    logic [ADR_W:0]    i_fillCount;
    logic              i_fillValue;
    logic              o_fillBusy;
    logic              o_fillDone;

    modport slave (
        input  i_fullMode, i_wrValid, i_wrAdr, i_wrPair, i_wrSelect, i_wrValue,
               i_wrValue16, i_wrMask16,
        input  i_rdValid, i_rdAdr, i_rdPair,
        input  i_fillStart, i_fillAdr, i_fillCount, i_fillValue,
        output o_wrReady, o_rdReady, o_rdValid, o_rdValue, o_rdValue16,
        output o_fillBusy, o_fillDone
    );

    modport master (
        output i_fullMode, i_wrValid, i_wrAdr, i_wrPair, i_wrSelect, i_wrValue,
               i_wrValue16, i_wrMask16,
        output i_rdValid, i_rdAdr, i_rdPair,
        output i_fillStart, i_fillAdr, i_fillCount, i_fillValue,
        input  o_wrReady, o_rdReady, o_rdValid, o_rdValue, o_rdValue16,
        input  o_fillBusy, o_fillDone
    );
endinterface

// File: rtl/stencil_cache_ctrl.sv
// stencil_cache_ctrl: two-bank per-pixel stencil bit cache with valid/ready
// write and read ports, bank-conflict arbitration and a bulk fill engine.
// Optional macro STENCIL_BYPASS_EN: a read colliding with a write to the
// identical address is accepted and returns write-first data.
module stencil_cache_ctrl #(
    parameter int ADR_W    = 15,
    parameter int PIX      = 16,
    parameter int BANK_BIT = 6
) (
    input  logic               clk,
    input  logic               rst,
    stencil_cache_ctrl_if.slave bus
);
    localparam int PW    = (PIX > 2) ? $clog2(PIX / 2) : 1;
    localparam int ROW_W = ADR_W - 1;
    localparam int DEPTH = 1 << ROW_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Row index is the word address with the bank-select bit squeezed out.
    function automatic logic [ROW_W-1:0] row_of(input logic [ADR_W-1:0] adr);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ROW_W; i++) begin
            r[i] = (int'(i) < BANK_BIT) ? adr[i] : adr[i+1];
        end
        return r;
    endfunction

    // Storage: bank A holds addresses with BANK_BIT = 1, bank B the rest.
    logic [PIX-1:0] mem_a [DEPTH];
    logic [PIX-1:0] mem_b [DEPTH];

    // Fill engine state
    logic [1:0]       state_q, state_d;
    logic [ADR_W-1:0] cursor_q, cursor_d;
    logic [ADR_W:0]   cnt_q, cnt_d;
    logic             fill_val_q, fill_val_d;
    logic             fill_busy, fill_done;

    // Read output registers
    logic             rd_valid_q;
    logic [1:0]       rd_value_q;
    logic [PIX-1:0]   rd_value16_q;

    // Arbitration
    logic             wr_bank, rd_bank;
    logic             conflict, bypass_ok;
    logic             wr_ready, rd_ready;
    logic             wr_fire, rd_fire;

    // Host write enables/data and the shared array write port
    logic [PIX-1:0]   hw_mask, hw_data;
    logic             wp_en;
    logic [ADR_W-1:0] wp_adr;
    logic [PIX-1:0]   wp_mask, wp_data;
    logic [ROW_W-1:0] wp_row;
    logic             wp_bank;

    // Read path
    logic [ROW_W-1:0] rd_row;
    logic [PIX-1:0]   arr_word, rd_word;
    logic [1:0]       rd_pair_val;

    assign fill_busy = (state_q != ST_IDLE);
    assign fill_done = (state_q == ST_DONE);
    assign wr_bank   = bus.i_wrAdr[BANK_BIT];
    assign rd_bank   = bus.i_rdAdr[BANK_BIT];

    // Bank conflict detection and the resulting ready outputs.
    always_comb begin
        conflict = bus.i_wrValid && (wr_bank == rd_bank) &&
                   (bus.i_fullMode || (bus.i_wrPair == bus.i_rdPair));
`ifdef STENCIL_BYPASS_EN
        bypass_ok = (bus.i_wrAdr == bus.i_rdAdr);
`else
        bypass_ok = 1'b0;
`endif
        wr_ready = !fill_busy;
        rd_ready = !fill_busy && !(conflict && !bypass_ok);
        wr_fire  = bus.i_wrValid && wr_ready;
        rd_fire  = bus.i_rdValid && rd_ready;
    end

    // Host write: per-bit enables and data for pair or whole-word mode.
    always_comb begin
        hw_mask = '0;
        hw_data = '0;
        if (bus.i_fullMode) begin
            hw_mask = bus.i_wrMask16;
            hw_data = bus.i_wrValue16;
        end else begin
            for (int unsigned p = 0; p < PIX / 2; p++) begin
                if (bus.i_wrPair == PW'(p)) begin
                    hw_mask[2*p]   = bus.i_wrSelect[0];
                    hw_mask[2*p+1] = bus.i_wrSelect[1];
                end
            end
            hw_data = {(PIX / 2){bus.i_wrValue}};
        end
    end

    // Array write port: the fill engine owns it while filling, otherwise the host.
    always_comb begin
        wp_en   = wr_fire;
        wp_adr  = bus.i_wrAdr;
        wp_mask = hw_mask;
        wp_data = hw_data;
        if (state_q == ST_FILL) begin
            wp_en   = 1'b1;
            wp_adr  = cursor_q;
            wp_mask = '1;
            wp_data = {PIX{fill_val_q}};
        end
        wp_row  = row_of(wp_adr);
        wp_bank = wp_adr[BANK_BIT];
    end

    // Bit-enabled array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wp_en) begin
            for (int unsigned b = 0; b < PIX; b++) begin
                if (wp_mask[b]) begin
                    if (wp_bank) begin
                        mem_a[wp_row][b] <= wp_data[b];
                    end else begin
                        mem_b[wp_row][b] <= wp_data[b];
                    end
                end
            end
        end
    end

    // Read word lookup, with write-first merge when a same-address conflict is bypassed.
    always_comb begin
        rd_row   = row_of(bus.i_rdAdr);
        arr_word = rd_bank ? mem_a[rd_row] : mem_b[rd_row];
        rd_word  = arr_word;
        if (conflict && bypass_ok) begin
            rd_word = (arr_word & ~hw_mask) | (hw_data & hw_mask);
        end
        rd_pair_val = rd_word[{bus.i_rdPair, 1'b0} +: 2];
    end

    // Read output registers: valid pulses one cycle, data holds until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q   <= 1'b0;
            rd_value_q   <= '0;
            rd_value16_q <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_value_q   <= rd_pair_val;
                rd_value16_q <= rd_word;
            end
        end
    end

    // Fill engine next-state: capture in IDLE, one word per FILL cycle, single DONE cycle.
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        cnt_d      = cnt_q;
        fill_val_d = fill_val_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_fillStart) begin
                    cursor_d   = bus.i_fillAdr;
                    cnt_d      = bus.i_fillCount;
                    fill_val_d = bus.i_fillValue;
                    state_d    = (bus.i_fillCount != '0) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                cursor_d = cursor_q + ADR_W'(1);
                cnt_d    = cnt_q - (ADR_W + 1)'(1);
                if (cnt_q == (ADR_W + 1)'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fill engine registers; reset abandons any fill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cursor_q   <= '0;
            cnt_q      <= '0;
            fill_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            cnt_q      <= cnt_d;
            fill_val_q <= fill_val_d;
        end
    end

    assign bus.o_wrReady   = wr_ready;
    assign bus.o_rdReady   = rd_ready;
    assign bus.o_rdValid   = rd_valid_q;
    assign bus.o_rdValue   = rd_value_q;
    assign bus.o_rdValue16 = rd_value16_q;
    assign bus.o_fillBusy  = fill_busy;
    assign bus.o_fillDone  = fill_done;
endmodule

// File: tb/tb_stencil_cache_ctrl.sv
// tb_stencil_cache_ctrl: directed scenarios plus randomized traffic checked
// against a word-array reference model of the stencil cache.
module tb_stencil_cache_ctrl;
    localparam int ADR_W = 15;
    localparam int PIX   = 16;
    localparam int BANK  = 6;
    localparam int WORDS = 1 << ADR_W;

    logic clk;
    logic rst;

    stencil_cache_ctrl_if #(.ADR_W(ADR_W), .PIX(PIX)) bus ();

    stencil_cache_ctrl #(.ADR_W(ADR_W), .PIX(PIX), .BANK_BIT(BANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [15:0] mem_m   [WORDS];
    logic [15:0] known_m [WORDS];
    int          left_m;          // remaining busy cycles of the current fill
    int unsigned fcur_m;
    logic        fval_m;
    logic [15:0] e16, e16m;
    logic [1:0]  e2, e2m;

    // What the DUT showed in the most recent step (for scenario-specific checks)
    logic        seen_rdy, seen_busy, seen_done;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_fullMode  = 1'b0;
        bus.i_wrValid   = 1'b0;
        bus.i_wrAdr     = '0;
        bus.i_wrPair    = '0;
        bus.i_wrSelect  = '0;
        bus.i_wrValue   = '0;
        bus.i_wrValue16 = '0;
        bus.i_wrMask16  = '0;
        bus.i_rdValid   = 1'b0;
        bus.i_rdAdr     = '0;
        bus.i_rdPair    = '0;
        bus.i_fillStart = 1'b0;
        bus.i_fillAdr   = '0;
        bus.i_fillCount = '0;
        bus.i_fillValue = 1'b0;
    endtask

    // One clock cycle: check readies/status against the model, advance the model,
    // cross the edge and check the read outputs. Entered and left at posedge+1.
    task automatic step();
        logic busy_m, done_m, wrdy, rrdy, conf, byp, wr_fire, rd_fire;
        logic [15:0] wmask, wdata, word, km;
        int unsigned wa, ra, rp;
        #1;
        busy_m = (left_m != 0);
        done_m = (left_m == 1);
        wrdy   = !busy_m;
        conf   = bus.i_wrValid && (bus.i_wrAdr[BANK] == bus.i_rdAdr[BANK]) &&
                 (bus.i_fullMode || (bus.i_wrPair == bus.i_rdPair));
`ifdef STENCIL_BYPASS_EN
        byp = conf && (bus.i_wrAdr == bus.i_rdAdr);
`else
        byp = 1'b0;
`endif
        rrdy = !busy_m && !(conf && !byp);
        seen_rdy  = bus.o_rdReady;
        seen_busy = bus.o_fillBusy;
        seen_done = bus.o_fillDone;
        chk_eq("wrReady",  32'(bus.o_wrReady),  32'(wrdy));
        chk_eq("rdReady",  32'(bus.o_rdReady),  32'(rrdy));
        chk_eq("fillBusy", 32'(bus.o_fillBusy), 32'(busy_m));
        chk_eq("fillDone", 32'(bus.o_fillDone), 32'(done_m));

        wr_fire = bus.i_wrValid && wrdy;
        rd_fire = bus.i_rdValid && rrdy;
        wa = int'(bus.i_wrAdr);
        ra = int'(bus.i_rdAdr);
        rp = int'(bus.i_rdPair);
        if (bus.i_fullMode) begin
            wmask = bus.i_wrMask16;
            wdata = bus.i_wrValue16;
        end else begin
            wmask = 16'(bus.i_wrSelect) << (2 * int'(bus.i_wrPair));
            wdata = {8{bus.i_wrValue}};
        end

        if (rd_fire) begin
            word = mem_m[ra];
            km   = known_m[ra];
            if (byp) begin
                word = (word & ~wmask) | (wdata & wmask);
                km   = km | wmask;
            end
            e16  = word;
            e16m = km;
            e2   = word[2*rp +: 2];
            e2m  = km[2*rp +: 2];
        end
        if (wr_fire) begin
            mem_m[wa]   = (mem_m[wa] & ~wmask) | (wdata & wmask);
            known_m[wa] = known_m[wa] | wmask;
        end
        if (left_m > 0) begin
            if (left_m > 1) begin
                mem_m[fcur_m]   = fval_m ? 16'hFFFF : 16'h0000;
                known_m[fcur_m] = 16'hFFFF;
                fcur_m          = (fcur_m + 1) % WORDS;
            end
            left_m--;
        end else if (bus.i_fillStart) begin
            fcur_m = int'(bus.i_fillAdr);
            fval_m = bus.i_fillValue;
            left_m = int'(bus.i_fillCount) + 1;
        end

        @(posedge clk);
        #1;
        chk_eq("rdValid",   32'(bus.o_rdValid), 32'(rd_fire));
        chk_eq("rdValue16", 32'(bus.o_rdValue16 & e16m), 32'(e16 & e16m));
        chk_eq("rdValue",   32'(bus.o_rdValue & e2m), 32'(e2 & e2m));
        bus.i_wrValid   = 1'b0;
        bus.i_rdValid   = 1'b0;
        bus.i_fillStart = 1'b0;
    endtask

    task automatic model_reset();
        left_m = 0;
        e16    = '0;
        e16m   = 16'hFFFF;
        e2     = '0;
        e2m    = 2'b11;
    endtask

    task automatic start_fill(input int unsigned adr, input int unsigned cnt, input logic val);
        bus.i_fillStart = 1'b1;
        bus.i_fillAdr   = ADR_W'(adr);
        bus.i_fillCount = (ADR_W + 1)'(cnt);
        bus.i_fillValue = val;
        step();
    endtask

    task automatic read_word(input int unsigned adr, input int unsigned pair);
        bus.i_rdValid = 1'b1;
        bus.i_rdAdr   = ADR_W'(adr);
        bus.i_rdPair  = 3'(pair);
        step();
    endtask

    int unsigned busy_cnt, done_at, done_cnt;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem_m[i]   = '0;
            known_m[i] = '0;
        end
        fcur_m = 0;
        fval_m = 1'b0;
        model_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_fillBusy", 32'(bus.o_fillBusy), 32'd0);
        chk_eq("rst_fillDone", 32'(bus.o_fillDone), 32'd0);
        chk_eq("rst_rdValid",  32'(bus.o_rdValid), 32'd0);
        chk_eq("rst_rdValue16", 32'(bus.o_rdValue16), 32'd0);
        chk_eq("rst_rdValue",  32'(bus.o_rdValue), 32'd0);
        rst = 1'b0;

        // Clear the working region 0x000-0x1FF so every read there is fully known.
        start_fill(0, 512, 1'b0);
        for (int i = 0; i < 520 && left_m != 0; i++) step();

        // Pair write then read back
        bus.i_wrValid = 1'b1; bus.i_fullMode = 1'b0; bus.i_wrAdr = 15'h0045;
        bus.i_wrPair = 3'd3; bus.i_wrSelect = 2'b11; bus.i_wrValue = 2'b10;
        step();
        read_word(15'h0045, 3);
        chk_eq("pair_rdValue", 32'(bus.o_rdValue), 32'h2);
        chk_eq("pair_rd16_7_6", 32'(bus.o_rdValue16[7:6]), 32'h2);

        // Masked full-mode write over a filled word
        start_fill(15'h00C0, 1, 1'b0);
        for (int i = 0; i < 4 && left_m != 0; i++) step();
        bus.i_wrValid = 1'b1; bus.i_fullMode = 1'b1; bus.i_wrAdr = 15'h00C0;
        bus.i_wrValue16 = 16'hA5A5; bus.i_wrMask16 = 16'h00FF;
        step();
        read_word(15'h00C0, 0);
        chk_eq("masked_rd16", 32'(bus.o_rdValue16), 32'h00A5);

        // Different-bank write/read: both accepted
        bus.i_wrValid = 1'b1; bus.i_fullMode = 1'b1; bus.i_wrAdr = 15'h0040;
        bus.i_wrValue16 = 16'h1234; bus.i_wrMask16 = 16'hFFFF;
        bus.i_rdValid = 1'b1; bus.i_rdAdr = 15'h0001; bus.i_rdPair = 3'd0;
        step();
        chk_eq("diffbank_rdReady", 32'(seen_rdy), 32'd1);

        // Same-bank full-mode write blocks the read; retry goes through
        bus.i_wrValid = 1'b1; bus.i_fullMode = 1'b1; bus.i_wrAdr = 15'h0040;
        bus.i_wrValue16 = 16'h4321; bus.i_wrMask16 = 16'hFFFF;
        bus.i_rdValid = 1'b1; bus.i_rdAdr = 15'h0041; bus.i_rdPair = 3'd0;
        step();
        chk_eq("samebank_rdReady", 32'(seen_rdy), 32'd0);
        bus.i_fullMode = 1'b0;
        read_word(15'h0041, 0);
        chk_eq("samebank_retry_rdReady", 32'(seen_rdy), 32'd1);

        // Same-address pair conflict
        bus.i_wrValid = 1'b1; bus.i_fullMode = 1'b0; bus.i_wrAdr = 15'h0100;
        bus.i_wrPair = 3'd2; bus.i_wrSelect = 2'b11; bus.i_wrValue = 2'b01;
        bus.i_rdValid = 1'b1; bus.i_rdAdr = 15'h0100; bus.i_rdPair = 3'd2;
        step();
`ifdef STENCIL_BYPASS_EN
        chk_eq("sameadr_rdReady", 32'(seen_rdy), 32'd1);
        chk_eq("sameadr_rdValue", 32'(bus.o_rdValue), 32'h1);
`else
        chk_eq("sameadr_rdReady", 32'(seen_rdy), 32'd0);
        read_word(15'h0100, 2);
        chk_eq("sameadr_retry_rdValue", 32'(bus.o_rdValue), 32'h1);
`endif

        // Wrapping fill
        start_fill(15'h7FFE, 4, 1'b1);
        busy_cnt = 0; done_at = 0;
        for (int i = 0; i < 8; i++) begin
            bus.i_wrValid = 1'b1; bus.i_rdValid = 1'b1;
            bus.i_wrAdr = 15'h0002; bus.i_rdAdr = 15'h0003; bus.i_fullMode = 1'b0;
            bus.i_wrSelect = 2'b00;
            step();
            if (seen_busy) busy_cnt++;
            if (seen_done) done_at = busy_cnt;
        end
        chk_eq("wrap_busy_cycles", busy_cnt, 32'd5);
        chk_eq("wrap_done_cycle", done_at, 32'd5);
        read_word(15'h7FFE, 0); chk_eq("wrap_7FFE", 32'(bus.o_rdValue16), 32'hFFFF);
        read_word(15'h7FFF, 0); chk_eq("wrap_7FFF", 32'(bus.o_rdValue16), 32'hFFFF);
        read_word(15'h0000, 0); chk_eq("wrap_0000", 32'(bus.o_rdValue16), 32'hFFFF);
        read_word(15'h0001, 0); chk_eq("wrap_0001", 32'(bus.o_rdValue16), 32'hFFFF);

        // Reset in the middle of a fill
        start_fill(15'h0020, 8, 1'b1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk_eq("midrst_fillBusy", 32'(bus.o_fillBusy), 32'd0);
        chk_eq("midrst_fillDone", 32'(bus.o_fillDone), 32'd0);
        chk_eq("midrst_rdValid", 32'(bus.o_rdValid), 32'd0);
        chk_eq("midrst_rdValue16", 32'(bus.o_rdValue16), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (seen_done) done_cnt++;
        end
        chk_eq("midrst_no_done", done_cnt, 32'd0);
        start_fill(15'h0020, 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (seen_done) done_cnt++;
        end
        chk_eq("postrst_fill_done", done_cnt, 32'd1);

        // Randomized traffic within the cleared region
        for (int i = 0; i < 800; i++) begin
            bus.i_fullMode  = 1'($urandom_range(0, 1));
            bus.i_wrValid   = ($urandom_range(0, 3) != 0);
            bus.i_wrAdr     = 15'($urandom_range(0, 255));
            bus.i_wrPair    = 3'($urandom_range(0, 7));
            bus.i_wrSelect  = 2'($urandom_range(0, 3));
            bus.i_wrValue   = 2'($urandom_range(0, 3));
            bus.i_wrValue16 = 16'($urandom);
            bus.i_wrMask16  = 16'($urandom);
            bus.i_rdValid   = ($urandom_range(0, 2) != 0);
            bus.i_rdAdr     = ($urandom_range(0, 3) == 0) ? bus.i_wrAdr : 15'($urandom_range(0, 255));
            bus.i_rdPair    = ($urandom_range(0, 2) == 0) ? bus.i_wrPair : 3'($urandom_range(0, 7));
            bus.i_fillStart = ($urandom_range(0, 24) == 0);
            bus.i_fillAdr   = 15'($urandom_range(0, 250));
            bus.i_fillCount = 16'($urandom_range(0, 5));
            bus.i_fillValue = 1'($urandom_range(0, 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
